// File: rtl/key_conditioner.sv
// Four-channel push-button conditioner: 2-flop synchroniser, per-key debounce FSM,
// press/release/long pulses. Define KEY_REPEAT_EN to add auto-repeat press pulses.
module key_conditioner #(
  parameter int NKEYS           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 1000,
  parameter int REPEAT_CYCLES   = 200
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NKEYS-1:0] key_i,
  output logic [NKEYS-1:0] level_o,
  output logic [NKEYS-1:0] press_o,
  output logic [NKEYS-1:0] release_o,
  output logic [NKEYS-1:0] long_o,
  output logic             busy_o
);

  // state        | meaning
  // IDLE         | debounced released, waiting for a pressed sample
  // PRESS_WAIT   | counting stable pressed samples
  // HELD         | debounced pressed, hold counter running
  // RELEASE_WAIT | counting stable released samples, hold counter frozen
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW = $clog2(LONG_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_ONE    = DW'(1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  state_t           state_q [NKEYS];
  state_t           state_d [NKEYS];
  logic [DW-1:0]    cnt_q   [NKEYS];
  logic [DW-1:0]    cnt_d   [NKEYS];
  logic [HW-1:0]    hold_q  [NKEYS];
  logic [HW-1:0]    hold_d  [NKEYS];
  logic [NKEYS-1:0] sync1_q, sync2_q;
  logic [NKEYS-1:0] level_q, level_d;
  logic [NKEYS-1:0] press_q, press_d;
  logic [NKEYS-1:0] release_q, release_d;
  logic [NKEYS-1:0] long_q, long_d;
  logic [NKEYS-1:0] s;

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_q [NKEYS];
  logic [RW-1:0] rep_d [NKEYS];
`else
  // Repeat period has no effect without auto-repeat.
  logic unused_repeat_cycles;
  assign unused_repeat_cycles = ^REPEAT_CYCLES;
`endif

  assign s = ~sync2_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      for (int k = 0; k < NKEYS; k++) begin
        state_q[k] <= IDLE;
        cnt_q[k]   <= '0;
        hold_q[k]  <= '0;
`ifdef KEY_REPEAT_EN
        rep_q[k]   <= '0;
`endif
      end
    end else begin
      sync1_q   <= key_i;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      for (int k = 0; k < NKEYS; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
        hold_q[k]  <= hold_d[k];
`ifdef KEY_REPEAT_EN
        rep_q[k]   <= rep_d[k];
`endif
      end
    end
  end

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    for (int k = 0; k < NKEYS; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      hold_d[k]  = hold_q[k];
`ifdef KEY_REPEAT_EN
      rep_d[k]   = rep_q[k];
`endif
      case (state_q[k])
        IDLE: begin
          if (s[k]) begin
            state_d[k] = PRESS_WAIT;
            cnt_d[k]   = DB_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!s[k]) begin
            state_d[k] = IDLE;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == DB_LAST) begin
            state_d[k] = HELD;
            cnt_d[k]   = '0;
            hold_d[k]  = '0;
            press_d[k] = 1'b1;
            level_d[k] = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + DB_ONE;
          end
        end
        HELD: begin
          if (!s[k]) begin
            state_d[k] = RELEASE_WAIT;
            cnt_d[k]   = DB_ONE;
          end else if (hold_q[k] != HOLD_MAX) begin
            hold_d[k] = hold_q[k] + 1'b1;
            if (hold_q[k] == HOLD_LAST) long_d[k] = 1'b1;
          end else begin
`ifdef KEY_REPEAT_EN
            // Saturated hold counter means long_o has fired; run the repeat timer.
            if (rep_q[k] == REP_LAST) begin
              press_d[k] = 1'b1;
              rep_d[k]   = '0;
            end else begin
              rep_d[k] = rep_q[k] + 1'b1;
            end
`endif
          end
        end
        RELEASE_WAIT: begin
          if (s[k]) begin
            state_d[k] = HELD;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == DB_LAST) begin
            state_d[k]   = IDLE;
            cnt_d[k]     = '0;
            hold_d[k]    = '0;
            release_d[k] = 1'b1;
            level_d[k]   = 1'b0;
`ifdef KEY_REPEAT_EN
            rep_d[k]     = '0;
`endif
          end else begin
            cnt_d[k] = cnt_q[k] + DB_ONE;
          end
        end
        default: begin
          state_d[k] = IDLE;
          cnt_d[k]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int k = 0; k < NKEYS; k++) begin
      if (state_q[k] == PRESS_WAIT || state_q[k] == RELEASE_WAIT) busy_o = 1'b1;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE=4, LONG=20, REPEAT=5.
// Expectations follow KEY_REPEAT_EN when it is defined for the build.
module tb_key_conditioner;

  logic       clock;
  logic       reset;
  logic [3:0] key_i;
  logic [3:0] level_o, press_o, release_o, long_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  int press_cnt [4];
  int rel_cnt   [4];
  int long_cnt  [4];
  int busy_rise = 0;
  logic busy_prev = 1'b0;

  int press_base [4];
  int rel_base   [4];
  int long_base  [4];
  int busy_base;

  key_conditioner #(
    .NKEYS(4), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(5)
  ) dut (
    .clock(clock), .reset(reset), .key_i(key_i),
    .level_o(level_o), .press_o(press_o), .release_o(release_o),
    .long_o(long_o), .busy_o(busy_o)
  );

  initial begin
    clock = 1'b0;
    forever #10 clock = ~clock;
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      press_cnt[k] = 0;
      rel_cnt[k]   = 0;
      long_cnt[k]  = 0;
    end
  end

  always @(negedge clock) begin
    for (int k = 0; k < 4; k++) begin
      if (press_o[k] === 1'b1)   press_cnt[k]++;
      if (release_o[k] === 1'b1) rel_cnt[k]++;
      if (long_o[k] === 1'b1)    long_cnt[k]++;
    end
    if (busy_o === 1'b1 && busy_prev !== 1'b1) busy_rise++;
    busy_prev = busy_o;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic mark();
    for (int k = 0; k < 4; k++) begin
      press_base[k] = press_cnt[k];
      rel_base[k]   = rel_cnt[k];
      long_base[k]  = long_cnt[k];
    end
    busy_base = busy_rise;
  endtask

  logic [2:0] exp_rep;
  logic       rep_en;

  initial begin
`ifdef KEY_REPEAT_EN
    rep_en = 1'b1;
`else
    rep_en = 1'b0;
`endif
    reset = 1'b0;
    key_i = 4'b0000;
    step(2);
    chk("rst_level",   32'(level_o),   32'h0);
    chk("rst_press",   32'(press_o),   32'h0);
    chk("rst_release", 32'(release_o), 32'h0);
    chk("rst_long",    32'(long_o),    32'h0);
    chk("rst_busy",    32'(busy_o),    32'h0);

    // All keys held low through reset: press after 6 edges.
    reset = 1'b1;
    step(5);
    chk("post_rst_press5", 32'(press_o), 32'h0);
    chk("post_rst_busy",   32'(busy_o),  32'h1);
    step(1);
    chk("post_rst_press6", 32'(press_o), 32'hF);
    chk("post_rst_level",  32'(level_o), 32'hF);
    step(1);
    chk("post_rst_pulse1", 32'(press_o), 32'h0);
    key_i = 4'hF;
    step(5);
    chk("all_rel5", 32'(release_o), 32'h0);
    step(1);
    chk("all_rel6",   32'(release_o), 32'hF);
    chk("all_rel_lv", 32'(level_o),   32'h0);
    step(3);

    // Clean press on key 3 with long press.
    mark();
    key_i = 4'b0111;
    step(6);
    chk("k3_press",  32'(press_o), 32'h8);
    chk("k3_level",  32'(level_o), 32'h8);
    step(19);
    chk("k3_long19", 32'(long_o), 32'h0);
    step(1);
    chk("k3_long20", 32'(long_o), 32'h8);
    step(24);
    chk("k3_press_cnt", 32'(press_cnt[3] - press_base[3]), rep_en ? 32'd5 : 32'd1);
    chk("k3_long_cnt",  32'(long_cnt[3] - long_base[3]), 32'd1);
    key_i = 4'hF;
    step(5);
    chk("k3_rel5", 32'(release_o), 32'h0);
    step(1);
    chk("k3_rel6",   32'(release_o), 32'h8);
    chk("k3_rel_lv", 32'(level_o),   32'h0);
    step(1);
    chk("k3_rel_cnt", 32'(rel_cnt[3] - rel_base[3]), 32'd1);
    step(3);

    // Bounce on key 1.
    mark();
    for (int i = 0; i < 5; i++) begin
      key_i[1] = 1'b0;
      step(2);
      key_i[1] = 1'b1;
      step(2);
    end
    step(10);
    chk("b_press",  32'(press_cnt[1] - press_base[1]), 32'd0);
    chk("b_rel",    32'(rel_cnt[1] - rel_base[1]), 32'd0);
    chk("b_level",  32'(level_o), 32'h0);
    chk("b_busy",   32'(busy_o), 32'h0);
    chk("b_toggle", 32'((busy_rise - busy_base) >= 2), 32'h1);

    // Simultaneous press on keys 0 and 2, then a short release glitch on key 2.
    mark();
    key_i = 4'b1010;
    step(6);
    chk("sim_press", 32'(press_o), 32'h5);
    step(1);
    chk("sim_once", 32'(press_o), 32'h0);
    key_i[2] = 1'b1;
    step(2);
    key_i[2] = 1'b0;
    step(10);
    chk("gl_rel",   32'(rel_cnt[2] - rel_base[2]), 32'd0);
    chk("gl_level", 32'(level_o), 32'h5);
    key_i = 4'hF;
    step(8);
    chk("sim_rel_cnt", 32'(rel_cnt[0] + rel_cnt[2] - rel_base[0] - rel_base[2]), 32'd2);
    chk("sim_rel_lv",  32'(level_o), 32'h0);
    step(3);

    // Reset during RELEASE_WAIT of key 3.
    key_i = 4'b0111;
    step(8);
    chk("mr_level", 32'(level_o), 32'h8);
    key_i = 4'hF;
    step(4);
    chk("mr_busy_rw", 32'(busy_o), 32'h1);
    mark();
    reset = 1'b0;
    step(1);
    chk("mr_level0", 32'(level_o),   32'h0);
    chk("mr_rel0",   32'(release_o), 32'h0);
    chk("mr_busy0",  32'(busy_o),    32'h0);
    reset = 1'b1;
    step(12);
    chk("mr_rel_cnt",   32'(rel_cnt[3] - rel_base[3]), 32'd0);
    chk("mr_press_cnt", 32'(press_cnt[3] - press_base[3]), 32'd0);
    chk("mr_busy",      32'(busy_o), 32'h0);

    // Key 0 held 40 cycles: long at 26, repeats at 31/36/41, release at 46.
    for (int i = 1; i <= 50; i++) begin
      if (i == 1) key_i = 4'b1110;
      step(1);
      if (i == 40) key_i = 4'hF;
      exp_rep[0] = (i == 6) || (rep_en && (i == 31 || i == 36 || i == 41));
      exp_rep[1] = (i == 26);
      exp_rep[2] = (i == 46);
      chk($sformatf("rep_c%0d", i), {29'd0, release_o[0], long_o[0], press_o[0]},
          {29'd0, exp_rep});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
